// File: rtl/alu_op_issuer.sv
// Request/response initiator for the pin-level 4-bit ALU.
// Drives operand/opcode pins, captures the result, and checks it against a golden model.
module alu_op_issuer #(
  parameter int ALU_LATENCY = 1,
  parameter int ERR_W       = 8,
  parameter bit CHECK_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [2:0]       req_op,
  output logic [7:0]       alu_ui,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       ui_q;
  logic [2:0]       op_q;
  logic             rv_q;
  logic [7:0]       res_q;
  logic             mis_q;
  logic [ERR_W-1:0] err_q;

  logic [7:0]       a8;
  logic [7:0]       b8;
  logic [7:0]       golden;
  logic             div0;
  logic             mis_d;
  logic [ERR_W-1:0] err_d;

  // The driven pins double as the latched golden operands.
  always_comb begin
    a8     = {4'b0000, ui_q[7:4]};
    b8     = {4'b0000, ui_q[3:0]};
    golden = 8'h00;
    unique case (op_q)
      3'b000:  golden = a8 + b8;
      3'b001:  golden = a8 - b8;
      3'b010:  golden = a8 * b8;
      3'b011:  golden = (b8 != 8'h00) ? (a8 / b8) : 8'hFF;
      3'b100:  golden = a8 & b8;
      3'b101:  golden = a8 | b8;
      default: golden = 8'h00;
    endcase
  end

  // Divide by zero has no defined result, so it never counts as a mismatch.
  always_comb begin
    div0  = (op_q == 3'b011) && (ui_q[3:0] == 4'h0);
    mis_d = CHECK_EN && !div0 && (alu_result != golden);
    err_d = err_q;
    if (mis_d && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ui_q    <= 8'h00;
      op_q    <= 3'b000;
      rv_q    <= 1'b0;
      res_q   <= 8'h00;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ui_q    <= {req_a, req_b};
            op_q    <= req_op;
            cnt_q   <= CNT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            res_q   <= alu_result;
            mis_q   <= mis_d;
            err_q   <= err_d;
            rv_q    <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rv_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign alu_ui       = ui_q;
  assign alu_op       = op_q;
  assign rsp_valid    = rv_q;
  assign rsp_result   = res_q;
  assign rsp_mismatch = mis_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized scoreboard bench for alu_op_issuer.
// A behavioural ALU drives alu_result; a monitor pops expected responses.
module tb_alu_op_issuer;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic [2:0] req_op = '0;
  logic       rsp_ready = 1'b0;
  logic [7:0] alu_result;

  logic       req_ready, rsp_valid, rsp_mismatch, busy;
  logic [7:0] alu_ui, rsp_result;
  logic [2:0] alu_op;
  logic [7:0] err_count;

  logic       req_ready2, rsp_valid2, rsp_mismatch2, busy2;
  logic [7:0] alu_ui2, rsp_result2;
  logic [2:0] alu_op2;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  alu_op_issuer #(.ALU_LATENCY(LAT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_ui(alu_ui), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mismatch(rsp_mismatch),
    .err_count(err_count), .busy(busy)
  );

  alu_op_issuer #(.ALU_LATENCY(LAT), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_ui(alu_ui2), .alu_op(alu_op2), .alu_result(alu_result),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result2), .rsp_mismatch(rsp_mismatch2),
    .err_count(err_count2), .busy(busy2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gold_f(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = (b == 0) ? 255 : a / b;
      4: r = a & b;
      5: r = a | b;
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  // Behavioural ALU: samples pins each edge, result visible LAT edges later.
  bit         corrupt = 1'b0;
  logic [7:0] cval = 8'h00;
  logic [7:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 8'h00;
  always @(posedge clk) begin
    pipe[0] <= corrupt ? cval : gold_f(int'(alu_ui[7:4]), int'(alu_ui[3:0]), int'(alu_op));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[LAT-1];

  // Consumer: random backpressure, forced low while hold is set.
  bit hold = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [7:0] res;
    logic       mis;
    int         e1;
    int         e2;
  } exp_t;
  exp_t sb[$];
  int   m_e1 = 0;
  int   m_e2 = 0;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mis));
        chk("err_count", 32'(err_count), 32'(e.e1));
        chk("err_count_w2", 32'(err_count2), 32'(e.e2));
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input bit cor,
                       input logic [7:0] cv);
    int w;
    exp_t e;
    logic [7:0] g;
    bit d0;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    g  = gold_f(int'(a), int'(b), int'(op));
    d0 = (op == 3'b011) && (b == 4'h0);
    corrupt = cor;
    cval    = cv;
    e.res = cor ? cv : g;
    e.mis = cor && !d0 && (cv != g);
    if (e.mis) begin
      if (m_e1 < 255) m_e1++;
      if (m_e2 < 3) m_e2++;
    end
    e.e1 = m_e1;
    e.e2 = m_e2;
    sb.push_back(e);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_op = op;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input bit cor,
                       input logic [7:0] cv);
    int n;
    issue(a, b, op, cor, cv);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 4'($urandom);
    req_b = 4'($urandom);
    req_op = 3'($urandom);
    chk("pins_after_accept", 32'(alu_ui), 32'({a, b}));
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(LAT + 1));
  endtask

  task automatic do_reset();
    sb.delete();
    m_e1 = 0;
    m_e2 = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] held_res;
    logic [7:0] held_ui;
    int w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_alu_ui", 32'(alu_ui), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_mismatch", 32'(rsp_mismatch), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    do_op(4'd7, 4'd9, 3'b000, 1'b0, 8'h00);
    do_op(4'd3, 4'd5, 3'b001, 1'b0, 8'h00);
    do_op(4'd15, 4'd15, 3'b010, 1'b0, 8'h00);
    do_op(4'd9, 4'd0, 3'b011, 1'b0, 8'h00);
    do_op(4'd1, 4'd1, 3'b101, 1'b1, 8'h00);
    do_op(4'd6, 4'd3, 3'b110, 1'b0, 8'h00);

    while (sb.size() != 0) @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_op(4'(i + 1), 4'd2, 3'b000, 1'b1, 8'hAA);
    end

    // Backpressure: response must hold and further requests be refused.
    while (sb.size() != 0) @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_op(4'd12, 4'd4, 3'b011, 1'b0, 8'h00);
    held_res = rsp_result;
    held_ui  = alu_ui;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_a = 4'($urandom);
      req_b = 4'($urandom);
      req_op = 3'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rsp_result", 32'(rsp_result), 32'(held_res));
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      chk("hold_alu_ui", 32'(alu_ui), 32'(held_ui));
    end
    req_valid = 1'b0;
    hold = 1'b0;

    // Reset during WAIT abandons the operation.
    while (sb.size() != 0) @(negedge clk);
    issue(4'd5, 4'd6, 3'b010, 1'b0, 8'h00);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_busy", 32'(busy), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("rstw_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rstw_alu_ui", 32'(alu_ui), 32'h0);
      chk("rstw_alu_op", 32'(alu_op), 32'h0);
      chk("rstw_req_ready", 32'(req_ready), 32'h1);
      chk("rstw_err_count", 32'(err_count), 32'h0);
      @(negedge clk);
    end

    for (int i = 0; i < 200; i++) begin
      logic [3:0] a, b;
      logic [2:0] op;
      bit cor;
      a   = 4'($urandom);
      b   = 4'($urandom);
      op  = 3'($urandom);
      cor = ($urandom_range(0, 3) == 0);
      do_op(a, b, op, cor, gold_f(int'(a), int'(b), int'(op)) ^ 8'h5A);
    end

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
